instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Initiator for the instruction memory read port. Generates sequential word addresses (r_adrs/r_en), collects returned words (r_valid/r_data) and presents them in program order to the arbiter over a valid/ready stream.
- An internal credit-limited FIFO absorbs memory latency and arbiter back-pressure.
- Supports a branch redirect that flushes queued instructions and discards in-flight responses.

Parameters:
- ADDR_W, 8: memory word-address width; PC width.
- DATA_W, 32: instruction width.
- DEPTH, 4: FIFO entries; also the cap on (FIFO occupancy + outstanding reads). Power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- r_adrs  out  ADDR_W  read address to memory.
- r_en  out  1  read request, one word per cycle while high.
- r_valid  in  1  memory response valid; responses return in request order, latency of 1 or more cycles.
- r_data  in  DATA_W  memory response word.
- instr  out  DATA_W  instruction to the arbiter (FIFO head).
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  arbiter accepts instr this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new PC, sampled when redirect=1.
- busy  out  1  high when outstanding reads are non-zero or FIFO is non-empty.

Behaviour:
- Reset (synchronous, highest priority):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=IDLE.
  - Outputs: r_en=0, r_adrs=RESET_PC, instr_valid=0, instr=0, instr_pc=0, busy=0.
- FSM states:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: issuing reads.
  - STALL: credit exhausted.
  - FLUSH: discard>0; no issue until discard reaches 0, then FETCH.
- Issue rule:
  - r_en=1 in FETCH when (occupancy + outstanding) < DEPTH and redirect=0.
  - r_adrs=pc is driven combinationally from the pc register.
  - On issue: pc<=pc+1, wrapping modulo 2^ADDR_W; outstanding increments.
- Stall: FETCH to STALL when the credit sum reaches DEPTH; STALL to FETCH in the cycle after the sum drops below DEPTH.
- Response handling:
  - r_valid=1 decrements outstanding.
  - If discard>0: discard decrements and the word is dropped.
  - Otherwise {pc_of_request, r_data} is pushed. The request PC is held in a per-entry shadow PC queue or derived from a response-PC counter.
  - r_valid with outstanding=0 is ignored and raises the sticky err flag.
- Output handshake:
  - instr_valid = FIFO non-empty; a pop occurs when instr_valid & instr_ready.
  - instr/instr_pc hold stable while valid and not ready.
  - Simultaneous push and pop is legal, including when the FIFO is full (the pop frees the slot) and when it is empty (no bypass; the pushed word appears next cycle).
  - FIFO latency: a response accepted in cycle N is visible on instr in cycle N+1.
- Redirect (priority over issue, push and pop; below reset):
  - FIFO cleared and no issue this cycle.
  - discard <= outstanding − (r_valid ? 1 : 0), i.e. a response arriving in the redirect cycle is dropped.
  - pc <= redirect_pc.
  - Next state: FLUSH if discard>0, else FETCH.
  - instr_valid=0 in the following cycle.
  - A redirect during FLUSH recomputes discard the same way.
- Credit invariant: occupancy + outstanding ≤ DEPTH at all times; FIFO overflow is impossible by construction.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs stat_issued [31:0], stat_dropped [31:0] and stat_stall_cycles [31:0].
  - Counters saturate at all-ones and clear on reset.
  - stat_dropped counts discarded responses.
  - stat_stall_cycles counts cycles in STALL.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - FSM state encoding (IDLE, FETCH, STALL, FLUSH).
  - Localparam for the count width, clog2(DEPTH)+1.
  - Typedef for the fetch entry {pc, data}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH×(ADDR_W+DATA_W) synchronous FIFO with push, pop, clear, occupancy and full/empty outputs.
  - Synchronous active-high reset.

Test Plan:
- Reset release, memory latency 1, instr_ready=1: r_adrs issues 0,1,2,…; instr shows mem[0] with instr_pc=0 in the 3rd cycle after reset deasserts, then one instruction per cycle in order.
- instr_ready=0 held for 20 cycles, DEPTH=4: r_en drops after 4 credits; exactly 4 entries held; FSM in STALL. Raising ready drains pcs 0–3 in order with no loss or duplication.
- Latency 3, redirect_pc=0x40 with 2 reads outstanding: both responses are dropped; next instr has instr_pc=0x40; no stale pcs appear.
- Redirect in the same cycle as r_valid and instr_ready: no pop is reported; the arriving word is dropped; discard equals outstanding−1.
- Wrap: redirect_pc=0xFE, ADDR_W=8: instr_pc sequence is FE, FF, 00, 01.
- Reset asserted mid-stall with 4 entries queued: next cycle instr_valid=0, busy=0, r_adrs=RESET_PC; late r_valid pulses set err.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// The optional statistics counters are built when FETCH_STATS_EN is defined.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        FLUSH
    } fetch_state_e;

    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int FETCH_CNT_W = cnt_w(FETCH_DEPTH);

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        en
    );
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read port, arbiter stream and redirect bundle of the fetch unit.
// master is the fetch unit; slave is the memory/arbiter side.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] r_adrs;
    logic              r_en;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              busy;
    logic              err;

    modport master (
        output r_adrs, r_en,
        input  r_valid, r_data,
        output instr, instr_pc, instr_valid,
        input  instr_ready,
        input  redirect, redirect_pc,
        output busy, err
    );

    modport slave (
        input  r_adrs, r_en,
        output r_valid, r_data,
        input  instr, instr_pc, instr_valid,
        output instr_ready,
        output redirect, redirect_pc,
        input  busy, err
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, data} fetch entries.
// Push into a full FIFO is accepted only when a pop frees the slot.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Credit-limited instruction fetch unit with branch redirect and flush.
// Define FETCH_STATS_EN to add saturating issue/drop/stall counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_issued,
    output logic [31:0] stat_dropped,
    output logic [31:0] stat_stall_cycles,
`endif
    instr_fetch_if.master bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t              outst_q, outst_d;
    cnt_t              disc_q, disc_d;
    logic              err_q, err_d;

    cnt_t              occ;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W:0]    credit;
    logic [CNT_W:0]    credit_n;
    logic              rsp_ok;
    logic              issue;
    logic              push;
    logic              pop;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({rsp_pc_q, bus.r_data}),
        .rdata ({head_pc, head_data}),
        .count (occ),
        .full  (full),
        .empty (empty)
    );

    assign credit = {1'b0, occ} + {1'b0, outst_q};

    always_comb begin
        rsp_ok   = bus.r_valid && (outst_q != '0);
        issue    = (state_q == FETCH) && (credit < DEPTH_C)
                   && !bus.redirect;
        pop      = bus.instr_valid && bus.instr_ready;
        push     = rsp_ok && (disc_q == '0) && !bus.redirect
                   && (!full || pop);
        credit_n = credit + (CNT_W + 1)'(issue) - (CNT_W + 1)'(pop);
        outst_d  = outst_q + cnt_t'(issue) - cnt_t'(rsp_ok);
        err_d    = err_q || (bus.r_valid && (outst_q == '0));
        pc_d     = issue ? pc_q + ADDR_W'(1) : pc_q;
        rsp_pc_d = push ? rsp_pc_q + ADDR_W'(1) : rsp_pc_q;
        disc_d   = disc_q;
        if (rsp_ok && (disc_q != '0)) begin
            disc_d = disc_q - cnt_t'(1);
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: state_d = (credit_n >= DEPTH_C) ? STALL : FETCH;
            STALL: state_d = (credit < DEPTH_C) ? FETCH : STALL;
            FLUSH: state_d = (disc_d == '0) ? FETCH : FLUSH;
            default: state_d = IDLE;
        endcase

        // Everything still in flight after a redirect belongs to the old path.
        if (bus.redirect) begin
            disc_d   = outst_q - cnt_t'(rsp_ok);
            pc_d     = bus.redirect_pc;
            rsp_pc_d = bus.redirect_pc;
            state_d  = (disc_d != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            disc_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            err_q    <= err_d;
        end
    end

    assign bus.r_adrs      = pc_q;
    assign bus.r_en        = issue;
    assign bus.instr_valid = !empty && !bus.redirect;
    assign bus.instr       = empty ? '0 : head_data;
    assign bus.instr_pc    = empty ? '0 : head_pc;
    assign bus.busy        = (outst_q != '0) || !empty;
    assign bus.err         = err_q;

`ifdef FETCH_STATS_EN
    logic [31:0] st_iss_q, st_iss_d;
    logic [31:0] st_drop_q, st_drop_d;
    logic [31:0] st_stall_q, st_stall_d;
    logic        drop;

    always_comb begin
        drop       = rsp_ok && ((disc_q != '0) || bus.redirect);
        st_iss_d   = sat_inc(st_iss_q, issue);
        st_drop_d  = sat_inc(st_drop_q, drop);
        st_stall_d = sat_inc(st_stall_q, state_q == STALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_iss_q   <= '0;
            st_drop_q  <= '0;
            st_stall_q <= '0;
        end else begin
            st_iss_q   <= st_iss_d;
            st_drop_q  <= st_drop_d;
            st_stall_q <= st_stall_d;
        end
    end

    assign stat_issued       = st_iss_q;
    assign stat_dropped      = st_drop_q;
    assign stat_stall_cycles = st_stall_q;
`endif

endmodule
